// File: rtl/uart_frame_ctrl.sv
// Frame sequencer between the UART RX/TX pair and the CNN core: loads one frame of
// pixels into the frame buffer, starts inference, and returns the class as an ASCII digit.
module uart_frame_ctrl #(
  parameter int N_PIXELS     = 784,
  parameter int ADDR_W       = 10,
  parameter int RESULT_W     = 4,
  parameter int TIMEOUT_CLKS = 1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_dv,
  input  logic [7:0]          rx_byte,
  output logic                tx_dv,
  output logic [7:0]          tx_byte,
  input  logic                tx_busy,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [7:0]          mem_wdata,
  output logic                start,
  input  logic                done,
  input  logic [RESULT_W-1:0] result,
  output logic                busy,
  output logic                frame_err,
  output logic                rx_drop
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START_INF,
    WAIT_DONE,
    SEND,
    WAIT_TX_HI,
    WAIT_TX_LO
  } state_t;

  localparam int              TMR_W    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(N_PIXELS - 1);
  localparam bit              SINGLE   = (N_PIXELS == 1);
  localparam bit              TMO_EN   = (TIMEOUT_CLKS > 0);

  // Class index mapped onto '0'.. ; wider indices wrap modulo 256.
  function automatic logic [7:0] ascii_digit(input logic [RESULT_W-1:0] r);
    logic [7:0] r8;
    r8 = 8'(r);
    return 8'h30 + r8;
  endfunction

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [TMR_W-1:0]  tmr;
  logic              accept;
  logic              timeout_hit;

  logic              mem_we_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [7:0]        mem_wdata_nx;
  logic              start_nx;
  logic              tx_dv_nx;
  logic [7:0]        tx_byte_nx;
  logic              busy_nx;
  logic              frame_err_nx;
  logic              rx_drop_nx;

  assign accept      = rx_dv && ((state == IDLE) || (state == LOAD));
  assign timeout_hit = TMO_EN && (state == LOAD) && !rx_dv && (tmr == TMR_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (rx_dv) state_nx = SINGLE ? START_INF : LOAD;
      LOAD: begin
        if (rx_dv) begin
          if (cnt == CNT_LAST) state_nx = START_INF;
        end else if (timeout_hit) begin
          state_nx = IDLE;
        end
      end
      START_INF:  state_nx = WAIT_DONE;
      WAIT_DONE:  if (done) state_nx = SEND;
      SEND:       if (!tx_busy) state_nx = WAIT_TX_HI;
      WAIT_TX_HI: if (tx_busy) state_nx = WAIT_TX_LO;
      WAIT_TX_LO: if (!tx_busy) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs; every output is a flop so it is glitch-free.
  always_comb begin
    mem_we_nx    = accept;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    if (accept) begin
      mem_addr_nx  = (state == IDLE) ? '0 : cnt;
      mem_wdata_nx = rx_byte;
    end
    start_nx   = (state == START_INF);
    tx_dv_nx   = (state == SEND) && !tx_busy;
    tx_byte_nx = tx_byte;
    if ((state == WAIT_DONE) && done) begin
      tx_byte_nx = ascii_digit(result);
    end
    busy_nx      = (state_nx != IDLE);
    frame_err_nx = timeout_hit;
    rx_drop_nx   = rx_dv && !accept;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      start     <= 1'b0;
      tx_dv     <= 1'b0;
      tx_byte   <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      rx_drop   <= 1'b0;
    end else begin
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      start     <= start_nx;
      tx_dv     <= tx_dv_nx;
      tx_byte   <= tx_byte_nx;
      busy      <= busy_nx;
      frame_err <= frame_err_nx;
      rx_drop   <= rx_drop_nx;
    end
  end

  // Byte count and inter-byte idle timer; the timer only runs while loading.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      tmr <= '0;
    end else begin
      if (accept) begin
        cnt <= (state == IDLE) ? ADDR_W'(1) : cnt + 1'b1;
      end else if (state_nx == IDLE) begin
        cnt <= '0;
      end
      tmr <= ((state == LOAD) && !rx_dv && !timeout_hit) ? tmr + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed-plus-random bench for uart_frame_ctrl: a 4-pixel instance with a 64-clock
// timeout and a single-pixel instance with the timeout disabled.
module tb_uart_frame_ctrl;
  localparam int NP = 4;
  localparam int AW = 10;
  localparam int RW = 4;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic reset;

  logic          rx_dv, tx_dv, tx_busy, mem_we, start, done, busy, frame_err, rx_drop;
  logic [7:0]    rx_byte, tx_byte, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [RW-1:0] result;

  logic          rx_dv_b, tx_dv_b, tx_busy_b, mem_we_b, start_b, done_b, busy_b, frame_err_b, rx_drop_b;
  logic [7:0]    rx_byte_b, tx_byte_b, mem_wdata_b;
  logic [AW-1:0] mem_addr_b;
  logic [RW-1:0] result_b;

  int tests = 0;
  int fails = 0;
  logic [7:0] pix [NP];

  always #5 clk = ~clk;

  uart_frame_ctrl #(.N_PIXELS(NP), .ADDR_W(AW), .RESULT_W(RW), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_byte(rx_byte), .tx_dv(tx_dv),
    .tx_byte(tx_byte), .tx_busy(tx_busy), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .start(start), .done(done), .result(result), .busy(busy),
    .frame_err(frame_err), .rx_drop(rx_drop)
  );

  uart_frame_ctrl #(.N_PIXELS(1), .ADDR_W(AW), .RESULT_W(RW), .TIMEOUT_CLKS(0)) dut_b (
    .clk(clk), .reset(reset), .rx_dv(rx_dv_b), .rx_byte(rx_byte_b), .tx_dv(tx_dv_b),
    .tx_byte(tx_byte_b), .tx_busy(tx_busy_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .start(start_b), .done(done_b), .result(result_b), .busy(busy_b),
    .frame_err(frame_err_b), .rx_drop(rx_drop_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the reply character is ASCII '0' plus the class index, modulo 256.
  function automatic logic [7:0] exp_char(input int r);
    return 8'((48 + r) % 256);
  endfunction

  task automatic send_byte(input logic [7:0] b, input int idx);
    rx_dv   = 1'b1;
    rx_byte = b;
    step();
    rx_dv = 1'b0;
    chk("we", mem_we, 1);
    chk("addr", mem_addr, idx);
    chk("wdata", mem_wdata, b);
    chk("busy_load", busy, 1);
    chk("start_early", start, 0);
    chk("ferr_load", frame_err, 0);
  endtask

  task automatic finish_frame(input int res, input int drops, input int bp, input int blen);
    step();
    chk("start_pulse", start, 1);
    chk("we_after", mem_we, 0);
    step();
    chk("start_end", start, 0);
    for (int d = 0; d < drops; d++) begin
      rx_dv   = 1'b1;
      rx_byte = 8'($urandom);
      step();
      rx_dv = 1'b0;
      chk("drop", rx_drop, 1);
      chk("drop_we", mem_we, 0);
      step();
      chk("drop_end", rx_drop, 0);
    end
    if (bp > 0) tx_busy = 1'b1;
    done   = 1'b1;
    result = RW'(res);
    step();
    done   = 1'b0;
    result = RW'($urandom);
    chk("tx_byte", tx_byte, exp_char(res));
    chk("tx_dv_early", tx_dv, 0);
    repeat (bp) begin
      step();
      chk("tx_dv_bp", tx_dv, 0);
    end
    tx_busy = 1'b0;
    step();
    chk("tx_dv", tx_dv, 1);
    chk("tx_byte_dv", tx_byte, exp_char(res));
    step();
    chk("tx_dv_once", tx_dv, 0);
    tx_busy = 1'b1;
    repeat (blen) begin
      step();
      chk("busy_tx", busy, 1);
      chk("tx_dv_hold", tx_dv, 0);
    end
    tx_busy = 1'b0;
    step();
    chk("busy_idle", busy, 0);
    chk("tx_byte_hold", tx_byte, exp_char(res));
  endtask

  task automatic run_frame(input int res, input int drops, input int bp, input int blen,
                           input int maxgap);
    for (int i = 0; i < NP; i++) begin
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (gap) begin
        step();
        chk("gap_we", mem_we, 0);
        chk("gap_busy", busy, (i > 0) ? 1 : 0);
      end
      send_byte(pix[i], i);
    end
    finish_frame(res, drops, bp, blen);
  endtask

  task automatic rand_pix();
    for (int i = 0; i < NP; i++) pix[i] = 8'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    rx_dv = 1'b0; rx_byte = '0; tx_busy = 1'b0; done = 1'b0; result = '0;
    rx_dv_b = 1'b0; rx_byte_b = '0; tx_busy_b = 1'b0; done_b = 1'b0; result_b = '0;
    repeat (3) step();
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_start", start, 0);
    chk("rst_tx_dv", tx_dv, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_drop", rx_drop, 0);
    chk("rst_busy_b", busy_b, 0);
    reset = 1'b0;
    step();

    // Full frame with the directed pixel values.
    pix[0] = 8'h11; pix[1] = 8'h22; pix[2] = 8'h33; pix[3] = 8'h44;
    run_frame(7, 0, 0, 10, 0);

    // Timeout after two bytes, then a clean frame from address 0.
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 1);
    for (int k = 1; k <= TO; k++) begin
      step();
      chk("tmo_ferr", frame_err, (k == TO) ? 1 : 0);
      chk("tmo_start", start, 0);
      if (k == TO) chk("tmo_busy", busy, 0);
    end
    step();
    chk("tmo_ferr_end", frame_err, 0);
    rand_pix();
    run_frame(int'($urandom_range(15, 0)), 0, 0, 3, 2);

    // Bytes arriving while waiting for the core are dropped.
    rand_pix();
    run_frame(2, 3, 0, 4, 1);

    // Transmitter back-pressure on entry to SEND.
    rand_pix();
    run_frame(int'($urandom_range(15, 0)), 0, 5, 6, 0);

    // Reset in the middle of loading.
    send_byte(8'hC3, 0);
    send_byte(8'h5C, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tx_byte", tx_byte, 0);
    chk("mid_rst_start", start, 0);
    rand_pix();
    run_frame(int'($urandom_range(15, 0)), 0, 0, 2, 0);

    // A byte landing exactly on the timeout clock is accepted instead.
    rand_pix();
    send_byte(pix[0], 0);
    repeat (TO - 1) begin
      step();
      chk("edge_ferr", frame_err, 0);
    end
    for (int i = 1; i < NP; i++) send_byte(pix[i], i);
    finish_frame(9, 0, 0, 2);

    // Randomised frames.
    for (int f = 0; f < 4; f++) begin
      rand_pix();
      run_frame(int'($urandom_range(15, 0)), int'($urandom_range(2, 0)),
                int'($urandom_range(3, 0)), int'($urandom_range(8, 1)), 9);
    end

    // Single-pixel instance.
    rx_dv_b = 1'b1; rx_byte_b = 8'hFF;
    step();
    rx_dv_b = 1'b0;
    chk("b_we", mem_we_b, 1);
    chk("b_addr", mem_addr_b, 0);
    chk("b_wdata", mem_wdata_b, 8'hFF);
    chk("b_start_early", start_b, 0);
    chk("b_busy", busy_b, 1);
    step();
    chk("b_start", start_b, 1);
    chk("b_we_after", mem_we_b, 0);
    step();
    chk("b_start_end", start_b, 0);
    done_b = 1'b1; result_b = 4'd15;
    step();
    done_b = 1'b0;
    chk("b_tx_byte", tx_byte_b, exp_char(15));
    step();
    chk("b_tx_dv", tx_dv_b, 1);
    step();
    tx_busy_b = 1'b1;
    step();
    tx_busy_b = 1'b0;
    step();
    chk("b_busy_idle", busy_b, 0);
    rx_dv_b = 1'b1; rx_byte_b = 8'h3C;
    step();
    rx_dv_b = 1'b0;
    chk("b_we2", mem_we_b, 1);
    chk("b_addr2", mem_addr_b, 0);
    chk("b_ferr", frame_err_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
